// File: rtl/zrtc_pkg.sv
// Shared constants and types for the RTC glyph rendering path.
package zrtc_pkg;

    localparam int unsigned GLYPH_W     = 12;
    localparam int unsigned GLYPH_H     = 24;
    localparam int unsigned GLYPH_BYTES = (GLYPH_W * GLYPH_H) / 8;

    localparam logic [10:0] DIGIT_BASE  = 11'd1024;
    localparam logic [10:0] COLON_BASE  = 11'd1384;

    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_BLACK = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } zrtc_state_e;

    // Map one glyph bit to its RGB565 colour.
    function automatic logic [15:0] pix_color(input logic bit_val,
                                              input logic [15:0] fg,
                                              input logic [15:0] bg);
        return bit_val ? fg : bg;
    endfunction

endpackage

// File: rtl/zrtc_glyph_shifter.sv
// 8-bit glyph byte shifter: presents bits MSB first as pixels with valid/ready hold.
module zrtc_glyph_shifter
    import zrtc_pkg::*;
#(
    parameter logic [15:0] FG_COLOR = RGB565_WHITE,
    parameter logic [15:0] BG_COLOR = RGB565_BLACK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  load_data,
    input  logic        load_first,
    input  logic        load_last,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        char_first,
    output logic        pix_last,
    output logic        byte_done_c
);

    logic [7:0] sreg;
    logic [2:0] bit_cnt;
    logic       last_byte;
    logic       accept_c;
    logic [7:0] sreg_nxt_c;

    assign accept_c    = pix_valid && pix_ready;
    assign byte_done_c = accept_c && (bit_cnt == 3'd0);
    assign sreg_nxt_c  = {sreg[6:0], 1'b0};

    // Load a byte, then step one bit per accepted pixel; hold everything otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg       <= 8'd0;
            bit_cnt    <= 3'd0;
            last_byte  <= 1'b0;
            pix_valid  <= 1'b0;
            pix_data   <= BG_COLOR;
            char_first <= 1'b0;
            pix_last   <= 1'b0;
        end else if (load) begin
            sreg       <= load_data;
            bit_cnt    <= 3'd7;
            last_byte  <= load_last;
            pix_valid  <= 1'b1;
            pix_data   <= pix_color(load_data[7], FG_COLOR, BG_COLOR);
            char_first <= load_first;
            pix_last   <= 1'b0;
        end else if (accept_c) begin
            char_first <= 1'b0;
            if (bit_cnt == 3'd0) begin
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
            end else begin
                sreg     <= sreg_nxt_c;
                bit_cnt  <= bit_cnt - 3'd1;
                pix_data <= pix_color(sreg_nxt_c[7], FG_COLOR, BG_COLOR);
                pix_last <= last_byte && (bit_cnt == 3'd1);
            end
        end
    end

endmodule

// File: rtl/zrtc_glyph_reader.sv
// Walks the 8 time-string positions, fetches each glyph from ROM and streams RGB565 pixels.
module zrtc_glyph_reader
    import zrtc_pkg::*;
#(
    parameter int unsigned NUM_CHARS       = 8,
    parameter int unsigned BYTES_PER_GLYPH = GLYPH_BYTES,
    parameter int unsigned ROM_LAT         = 1,
    parameter logic [15:0] FG_COLOR        = RGB565_WHITE,
    parameter logic [15:0] BG_COLOR        = RGB565_BLACK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  char_sel,
    input  logic [10:0] glyph_base,
    output logic [10:0] rom_addr,
    output logic        rom_rd,
    input  logic [7:0]  rom_data,
    output logic        char_first,
    output logic [2:0]  char_idx,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [15:0] pix_data,
    output logic        pix_last
);

    localparam int unsigned CHAR_W = 3;
    localparam int unsigned BYTE_W = 6;
    localparam int unsigned WAIT_W = 2;
    localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(NUM_CHARS - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_GLYPH - 1);
    localparam logic [WAIT_W-1:0] WAIT_END  = WAIT_W'(ROM_LAT);

    zrtc_state_e       state;
    logic [CHAR_W-1:0] char_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [10:0]       base_q;
    logic              load_c;
    logic              byte_done_c;

    assign char_idx = char_cnt;
    assign char_sel = 4'(char_cnt);
    assign load_c   = (state == ST_WAIT) && (wait_cnt == WAIT_END);

    // Frame sequencer: position latch, byte fetch, shift-out and frame completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            char_cnt <= '0;
            byte_cnt <= '0;
            wait_cnt <= '0;
            base_q   <= 11'd0;
            rom_addr <= 11'd0;
            rom_rd   <= 1'b0;
        end else begin
            done   <= 1'b0;
            rom_rd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        char_cnt <= '0;
                        state    <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    base_q   <= glyph_base;
                    byte_cnt <= '0;
                    state    <= ST_READ;
                end
                ST_READ: begin
                    rom_addr <= base_q + 11'(byte_cnt);
                    rom_rd   <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (load_c) begin
                        state <= ST_SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (byte_done_c) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state <= ST_NEXT;
                        end else begin
                            byte_cnt <= byte_cnt + BYTE_W'(1);
                            state    <= ST_READ;
                        end
                    end
                end
                ST_NEXT: begin
                    if (char_cnt < LAST_CHAR) begin
                        char_cnt <= char_cnt + CHAR_W'(1);
                        state    <= ST_LATCH;
                    end else begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    zrtc_glyph_shifter #(
        .FG_COLOR (FG_COLOR),
        .BG_COLOR (BG_COLOR)
    ) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load_c),
        .load_data   (rom_data),
        .load_first  (byte_cnt == '0),
        .load_last   ((byte_cnt == LAST_BYTE) && (char_cnt == LAST_CHAR)),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .char_first  (char_first),
        .pix_last    (pix_last),
        .byte_done_c (byte_done_c)
    );

endmodule

// File: tb/tb_zrtc_glyph_reader.sv
// Scoreboard bench for zrtc_glyph_reader: ROM_LAT=1 and ROM_LAT=2 instances against a glyph model.
module tb_zrtc_glyph_reader;
    import zrtc_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic        first;
        logic        last;
        logic [2:0]  idx;
    } pix_t;

    logic        clk, rst_n, start, start2, pix_ready;
    logic        busy, done, rom_rd, char_first, pix_valid, pix_last;
    logic [3:0]  char_sel;
    logic [10:0] glyph_base, rom_addr;
    logic [7:0]  rom_data;
    logic [2:0]  char_idx;
    logic [15:0] pix_data;
    logic        busy2, done2, rom_rd2, char_first2, pix_valid2, pix_last2;
    logic [3:0]  char_sel2;
    logic [10:0] glyph_base2, rom_addr2;
    logic [7:0]  rom_data2, q2a;
    logic [2:0]  char_idx2;
    logic [15:0] pix_data2;

    logic [7:0]      mem [0:2047];
    logic [5:0][3:0] tdig;

    pix_t        exp_q[$], exp2_q[$], got_q[$];
    logic [10:0] addr_q[$];

    int checks = 0, errors = 0, cyc = 0;
    int pix1_cnt = 0, pix2_cnt = 0, done1_cnt = 0, done2_cnt = 0, hold_cnt = 0;
    int last1_cyc = 0;
    bit hold_pend = 0, done_prev = 0;
    pix_t hold_pix;

    function automatic logic [10:0] base_of(input logic [3:0] p, input logic [5:0][3:0] t);
        case (p)
            4'd0: return DIGIT_BASE + 11'(36 * int'(t[0]));
            4'd1: return DIGIT_BASE + 11'(36 * int'(t[1]));
            4'd3: return DIGIT_BASE + 11'(36 * int'(t[2]));
            4'd4: return DIGIT_BASE + 11'(36 * int'(t[3]));
            4'd6: return DIGIT_BASE + 11'(36 * int'(t[4]));
            4'd7: return DIGIT_BASE + 11'(36 * int'(t[5]));
            default: return COLON_BASE;
        endcase
    endfunction

    assign glyph_base  = base_of(char_sel, tdig);
    assign glyph_base2 = base_of(char_sel2, tdig);

    zrtc_glyph_reader #(.ROM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .char_sel(char_sel), .glyph_base(glyph_base), .rom_addr(rom_addr), .rom_rd(rom_rd),
        .rom_data(rom_data), .char_first(char_first), .char_idx(char_idx),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last)
    );

    zrtc_glyph_reader #(.ROM_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .char_sel(char_sel2), .glyph_base(glyph_base2), .rom_addr(rom_addr2), .rom_rd(rom_rd2),
        .rom_data(rom_data2), .char_first(char_first2), .char_idx(char_idx2),
        .pix_valid(pix_valid2), .pix_ready(pix_ready), .pix_data(pix_data2), .pix_last(pix_last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Glyph ROMs: one register stage for instance 1, two for instance 2.
    always @(posedge clk) begin
        if (rom_rd) rom_data <= mem[rom_addr];
        if (rom_rd2) q2a <= mem[rom_addr2];
        rom_data2 <= q2a;
    end

    // Monitor for the ROM_LAT=1 instance: address and pixel scoreboards, hold and done checks.
    always @(negedge clk) begin
        pix_t g, e;
        logic [10:0] ea;
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            g = '{data: pix_data, first: char_first, last: pix_last, idx: char_idx};
            if (rom_rd) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++; $display("FAIL rom_rd unexpected addr=%0d", rom_addr);
                end else begin
                    ea = addr_q.pop_front();
                    if (rom_addr !== ea) begin
                        errors++; $display("FAIL rom_addr got %0d exp %0d", rom_addr, ea);
                    end
                end
            end
            if (hold_pend) begin
                checks++; hold_cnt++;
                if (pix_valid !== 1'b1 || g !== hold_pix) begin
                    errors++; $display("FAIL hold valid=%b got %h exp %h", pix_valid, g, hold_pix);
                end
            end
            hold_pend = (pix_valid === 1'b1) && (pix_ready === 1'b0);
            hold_pix  = g;
            if (pix_valid && pix_ready) begin
                checks++; pix1_cnt++;
                got_q.push_back(g);
                if (pix_last) last1_cyc = cyc;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL pix unexpected got %h", g);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        errors++; $display("FAIL pix n=%0d got %h exp %h", pix1_cnt, g, e);
                    end
                end
            end
            if (done) begin
                checks++; done1_cnt++;
                if (done_prev || (cyc - last1_cyc) < 1 || (cyc - last1_cyc) > 3) begin
                    errors++; $display("FAIL done_timing gap got %0d exp 1..3 wide=%b", cyc - last1_cyc, done_prev);
                end
            end
            done_prev = done;
        end
    end

    // Monitor for the ROM_LAT=2 instance: pixel scoreboard and done count.
    always @(negedge clk) begin
        pix_t g, e;
        if (rst_n) begin
            if (pix_valid2 && pix_ready) begin
                g = '{data: pix_data2, first: char_first2, last: pix_last2, idx: char_idx2};
                checks++; pix2_cnt++;
                if (exp2_q.size() == 0) begin
                    errors++; $display("FAIL pix2 unexpected got %h", g);
                end else begin
                    e = exp2_q.pop_front();
                    if (g !== e) begin
                        errors++; $display("FAIL pix2 n=%0d got %h exp %h", pix2_cnt, g, e);
                    end
                end
            end
            if (done2) done2_cnt++;
        end
    end

    task automatic push_frame(input bit which);
        logic [10:0] b;
        logic [7:0]  by;
        pix_t        p;
        for (int c = 0; c < 8; c++) begin
            b = base_of(4'(c), tdig);
            for (int k = 0; k < 36; k++) begin
                if (!which) addr_q.push_back(b + 11'(k));
                by = mem[b + 11'(k)];
                for (int i = 7; i >= 0; i--) begin
                    p.data  = by[i] ? RGB565_WHITE : RGB565_BLACK;
                    p.first = (k == 0) && (i == 7);
                    p.last  = (c == 7) && (k == 35) && (i == 0);
                    p.idx   = 3'(c);
                    if (which) exp2_q.push_back(p); else exp_q.push_back(p);
                end
            end
        end
    endtask

    task automatic pulse_start(input bit which);
        @(posedge clk); #1;
        if (which) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int budget, input bit rnd, output bit ok);
        int d0 = which ? done2_cnt : done1_cnt;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
            if ((which ? done2_cnt : done1_cnt) != d0) begin ok = 1; break; end
        end
        pix_ready = 1'b1;
    endtask

    task automatic set_time(input logic [3:0] s0);
        tdig[0] = 4'd1; tdig[1] = 4'd2; tdig[2] = 4'd3;
        tdig[3] = 4'd4; tdig[4] = 4'd5; tdig[5] = s0;
    endtask

    task automatic test_reset();
        int rd_seen = 0, busy_seen = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, char_sel, rom_addr, rom_rd, char_first, char_idx, pix_valid, pix_data, pix_last} !== 39'd0
            || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals busy=%b done=%b sel=%0d addr=%0d rd=%b first=%b idx=%0d v=%b d=%h last=%b",
                     busy, done, char_sel, rom_addr, rom_rd, char_first, char_idx, pix_valid, pix_data, pix_last);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rom_rd) rd_seen++;
            if (busy) busy_seen++;
        end
        checks++;
        if (rd_seen != 0 || busy_seen != 0) begin
            errors++; $display("FAIL idle rd_cycles got %0d busy_cycles got %0d exp 0", rd_seen, busy_seen);
        end
    endtask

    task automatic test_linear_frame();
        bit ok;
        int p0 = pix1_cnt, d0 = done1_cnt;
        push_frame(0);
        pulse_start(0);
        wait_done(0, 6000, 0, ok);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL linear_timeout done not seen"); end
        checks++;
        if (pix1_cnt - p0 != 2304) begin errors++; $display("FAIL linear_count got %0d exp 2304", pix1_cnt - p0); end
        checks++;
        if (done1_cnt - d0 != 1 || exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++; $display("FAIL linear_tail dones %0d exp 1 left pix %0d addr %0d", done1_cnt - d0, exp_q.size(), addr_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL linear_busy got %b exp 0", busy); end
    endtask

    task automatic test_a5_pattern();
        bit ok;
        logic [15:0] tbl [8];
        tbl = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        mem[1060] = 8'hA5;
        got_q.delete();
        push_frame(0);
        pulse_start(0);
        wait_done(0, 6000, 0, ok);
        checks++;
        if (!ok || got_q.size() < 8) begin
            errors++; $display("FAIL a5_timeout ok=%b pixels %0d", ok, got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i].data !== tbl[i] || got_q[i].first !== (i == 0)) begin
                    errors++; $display("FAIL a5_pix%0d got %h/%b exp %h/%b", i, got_q[i].data, got_q[i].first, tbl[i], i == 0);
                end
            end
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        int p0 = pix1_cnt, h0 = hold_cnt;
        push_frame(0);
        pulse_start(0);
        wait_done(0, 12000, 1, ok);
        repeat (5) @(posedge clk);
        checks++;
        if (!ok || pix1_cnt - p0 != 2304 || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_ready ok=%b count %0d exp 2304 left %0d", ok, pix1_cnt - p0, exp_q.size());
        end
        checks++;
        if (hold_cnt - h0 < 100) begin errors++; $display("FAIL rand_holds got %0d exp >=100", hold_cnt - h0); end
    endtask

    task automatic test_back_to_back();
        bit ok, found;
        int d0 = done1_cnt;
        push_frame(0);
        pulse_start(0);
        repeat (500) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid got %b exp 1", busy); end
        pulse_start(0);
        wait_done(0, 6000, 0, ok);
        repeat (50) @(posedge clk);
        checks++;
        if (!ok || done1_cnt - d0 != 1 || exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++; $display("FAIL start_while_busy dones %0d exp 1 left %0d", done1_cnt - d0, exp_q.size());
        end
        // Abort mid glyph 3 with async reset.
        d0 = done1_cnt;
        push_frame(0);
        pulse_start(0);
        found = 0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            if (char_idx == 3'd3 && pix_valid) found = 1;
        end
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete(); addr_q.delete();
        #1;
        checks++;
        if (!found || busy !== 1'b0 || pix_valid !== 1'b0 || rom_rd !== 1'b0 || char_idx !== 3'd0
            || pix_data !== 16'h0000 || pix_last !== 1'b0 || char_first !== 1'b0 || rom_addr !== 11'd0) begin
            errors++; $display("FAIL mid_reset found=%b busy=%b v=%b idx=%0d d=%h addr=%0d", found, busy, pix_valid, char_idx, pix_data, rom_addr);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        checks++;
        if (done1_cnt != d0) begin errors++; $display("FAIL reset_no_done dones %0d exp 0", done1_cnt - d0); end
        push_frame(0);
        pulse_start(0);
        wait_done(0, 6000, 0, ok);
        repeat (5) @(posedge clk);
        checks++;
        if (!ok || exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++; $display("FAIL restart ok=%b left pix %0d addr %0d", ok, exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_rom_lat2();
        bit ok, found;
        int p0 = pix2_cnt;
        set_time(4'd6);
        push_frame(1);
        pulse_start(1);
        found = 0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            if (char_idx2 == 3'd7 && pix_valid2) found = 1;
        end
        tdig[5] = 4'd7;
        wait_done(1, 6000, 0, ok);
        repeat (5) @(posedge clk);
        checks++;
        if (!found || !ok || pix2_cnt - p0 != 2304 || exp2_q.size() != 0) begin
            errors++; $display("FAIL lat2 found=%b ok=%b count %0d exp 2304 left %0d", found, ok, pix2_cnt - p0, exp2_q.size());
        end
        set_time(4'd6);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
        start = 1'b0; start2 = 1'b0; pix_ready = 1'b1;
        set_time(4'd6);
        test_reset();
        test_linear_frame();
        test_a5_pattern();
        test_random_ready();
        test_back_to_back();
        test_rom_lat2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
